// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial frame transmitter: start, data LSB first, optional parity, stop bits
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 signal,
    output logic                 busy,
    output logic                 done
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int INDEX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(DATA_BITS - 1);
    // The stop counter runs one step past the last stop bit: that extra step is
    // the edge closing the final stop cycle, where done fires and IDLE resumes.
    localparam logic [1:0]         STOP_END   = 2'(STOP_BITS);
    localparam logic               ODD_PARITY = (PARITY == 2);

    // Refuse to elaborate with parameter values the frame format cannot express
    generate
        if (DATA_BITS < 1 || DATA_BITS > 16 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 1) begin : g_bad_params
            $error("uart_tx: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [INDEX_W-1:0]   bit_index;
    logic [1:0]           stop_index;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;

    // Frame sequencer. Each state writes the line level for the cycle after
    // the edge, so the line trails the state by one cycle: the handshake edge
    // only arms the frame and the start bit appears on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_index  <= '0;
            stop_index <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            signal     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    signal <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        // Word and its parity are captured here so later
                        // changes on tx_data cannot disturb the frame.
                        shreg      <= tx_data;
                        parity_bit <= (^tx_data) ^ ODD_PARITY;
                        timer      <= '0;
                        bit_index  <= '0;
                        stop_index <= '0;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    signal <= 1'b1;
                    if (timer == TIMER_LAST) begin
                        timer     <= '0;
                        bit_index <= '0;
                        state     <= S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_DATA: begin
                    signal <= shreg[0];
                    if (timer == TIMER_LAST) begin
                        timer <= '0;
                        shreg <= shreg >> 1;
                        if (bit_index == INDEX_LAST) begin
                            stop_index <= '0;
                            state      <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_PARITY: begin
                    signal <= parity_bit;
                    if (timer == TIMER_LAST) begin
                        timer      <= '0;
                        stop_index <= '0;
                        state      <= S_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_STOP: begin
                    signal <= 1'b0;
                    if (stop_index == STOP_END) begin
                        timer      <= '0;
                        stop_index <= '0;
                        busy       <= 1'b0;
                        tx_ready   <= 1'b1;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timer      <= '0;
                        stop_index <= stop_index + 2'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    signal   <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across several parameter sets
module tb_uart_tx;

    localparam int NI = 7;

    int cfg_d [NI] = '{8, 8, 8, 8, 4, 16, 1};
    int cfg_p [NI] = '{0, 1, 2, 0, 0, 1, 2};
    int cfg_s [NI] = '{1, 1, 1, 1, 2, 2, 1};
    int cfg_c [NI] = '{1, 1, 1, 4, 1, 3, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tx_data  [NI];
    logic        tx_valid [NI];
    logic        tx_ready [NI];
    logic        line     [NI];
    logic        busy     [NI];
    logic        done     [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1)) u0 (
        .clk(clk), .reset(rst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .signal(line[0]), .busy(busy[0]), .done(done[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .reset(rst), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .signal(line[1]), .busy(busy[1]), .done(done[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1)) u2 (
        .clk(clk), .reset(rst), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .signal(line[2]), .busy(busy[2]), .done(done[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u3 (
        .clk(clk), .reset(rst), .tx_data(tx_data[3][7:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .signal(line[3]), .busy(busy[3]), .done(done[3]));
    uart_tx #(.DATA_BITS(4), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(1)) u4 (
        .clk(clk), .reset(rst), .tx_data(tx_data[4][3:0]), .tx_valid(tx_valid[4]),
        .tx_ready(tx_ready[4]), .signal(line[4]), .busy(busy[4]), .done(done[4]));
    uart_tx #(.DATA_BITS(16), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(3)) u5 (
        .clk(clk), .reset(rst), .tx_data(tx_data[5]), .tx_valid(tx_valid[5]),
        .tx_ready(tx_ready[5]), .signal(line[5]), .busy(busy[5]), .done(done[5]));
    uart_tx #(.DATA_BITS(1), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(2)) u6 (
        .clk(clk), .reset(rst), .tx_data(tx_data[6][0:0]), .tx_valid(tx_valid[6]),
        .tx_ready(tx_ready[6]), .signal(line[6]), .busy(busy[6]), .done(done[6]));

    function automatic int frame_len(input int k);
        return (1 + cfg_d[k] + ((cfg_p[k] != 0) ? 1 : 0) + cfg_s[k]) * cfg_c[k];
    endfunction

    // Expected line, one entry per clock cycle starting with the first start-bit cycle
    function automatic logic [127:0] model_frame(input int k, input logic [15:0] data);
        logic       bits[$];
        logic [127:0] r;
        int         ones;
        int         pos;
        bits.push_back(1'b1);
        ones = 0;
        for (int i = 0; i < cfg_d[k]; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (cfg_p[k] == 1) bits.push_back((ones % 2) == 1);
        if (cfg_p[k] == 2) bits.push_back((ones % 2) == 0);
        for (int i = 0; i < cfg_s[k]; i++) bits.push_back(1'b0);
        r   = '0;
        pos = 0;
        foreach (bits[b]) begin
            for (int c = 0; c < cfg_c[k]; c++) begin
                r[pos] = bits[b];
                pos++;
            end
        end
        return r;
    endfunction

    // Raise tx_valid and advance to just after the handshake edge
    task automatic start_frame(input int k, input logic [15:0] data, output bit ok);
        int t;
        tx_data[k]  = data;
        tx_valid[k] = 1'b1;
        t = 0;
        while (tx_ready[k] !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        ok = (tx_ready[k] === 1'b1);
        @(posedge clk); #1;
    endtask

    // Record the line for one frame plus the closing edge; optionally jiggle inputs while busy
    task automatic capture(input int k, input bit noise, output logic [127:0] got,
                           output int done_at, output int bad_status,
                           output logic ready_end, output logic busy_end);
        int f;
        f          = frame_len(k);
        got        = '0;
        done_at    = -1;
        bad_status = 0;
        if (busy[k] !== 1'b1 || tx_ready[k] !== 1'b0 || line[k] !== 1'b0) bad_status++;
        for (int j = 1; j <= f + 1; j++) begin
            if (noise && j < f) begin
                tx_valid[k] = 1'($urandom % 2);
                tx_data[k]  = 16'($urandom);
            end else if (noise) begin
                tx_valid[k] = 1'b0;
            end
            @(posedge clk); #1;
            if (j <= f) begin
                got[j-1] = line[k];
                if (busy[k] !== 1'b1 || tx_ready[k] !== 1'b0) bad_status++;
            end
            if (done[k] === 1'b1 && done_at < 0) done_at = j;
        end
        ready_end = tx_ready[k];
        busy_end  = busy[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = '0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({line[k], busy[k], done[k], tx_ready[k]} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got={sig,busy,done,ready}=%b exp=0001", k,
                         {line[k], busy[k], done[k], tx_ready[k]});
            end
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({line[0], busy[0], done[0], tx_ready[0]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=0001", {line[0], busy[0], done[0], tx_ready[0]});
        end
    endtask

    task automatic test_basic();
        logic [127:0] got;
        int done_at, bad;
        logic rdy, bsy;
        bit ok;
        start_frame(0, 16'h0049, ok);
        tx_valid[0] = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_handshake_timeout"); end
        capture(0, 1'b0, got, done_at, bad, rdy, bsy);
        n_checks++;
        if (got[9:0] !== 10'h093) begin
            n_fail++;
            $display("FAIL basic_line got=%b exp=%b", got[9:0], 10'h093);
        end
        n_checks++;
        if (got !== model_frame(0, 16'h0049)) begin
            n_fail++;
            $display("FAIL basic_model got=%h exp=%h", got, model_frame(0, 16'h0049));
        end
        n_checks++;
        if (done_at != 11 || rdy !== 1'b1 || bsy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done got done_at=%0d ready=%b busy=%b exp 11/1/0", done_at, rdy, bsy);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_status got=%0d bad cycles exp=0", bad); end
        @(posedge clk); #1;
        n_checks++;
        if (done[0] !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", done[0]); end
    endtask

    task automatic test_parity();
        logic [127:0] got;
        int done_at, bad;
        logic rdy, bsy;
        bit ok;
        for (int k = 1; k <= 2; k++) begin
            start_frame(k, 16'h0049, ok);
            tx_valid[k] = 1'b0;
            capture(k, 1'b0, got, done_at, bad, rdy, bsy);
            n_checks++;
            if (!ok || got[9] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL parity_bit k=%0d got=%b exp=%b", k, got[9], (k == 1));
            end
            n_checks++;
            if (got !== model_frame(k, 16'h0049) || done_at != 12 || bad != 0) begin
                n_fail++;
                $display("FAIL parity_frame k=%0d got=%h done_at=%0d bad=%0d exp=%h done_at=12",
                         k, got, done_at, bad, model_frame(k, 16'h0049));
            end
        end
    endtask

    task automatic test_slow_clock();
        logic [127:0] got;
        int done_at, bad;
        logic rdy, bsy;
        bit ok;
        start_frame(3, 16'h0001, ok);
        tx_valid[3] = 1'b0;
        capture(3, 1'b0, got, done_at, bad, rdy, bsy);
        n_checks++;
        if (!ok || got[39:0] !== 40'h00000000FF) begin
            n_fail++;
            $display("FAIL slow_line got=%h exp=%h", got[39:0], 40'h00000000FF);
        end
        n_checks++;
        if (done_at != 41 || bad != 0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_done got done_at=%0d bad=%0d ready=%b exp 41/0/1", done_at, bad, rdy);
        end
    endtask

    task automatic test_stop_bits();
        logic [127:0] got;
        int done_at, bad;
        logic rdy, bsy;
        bit ok;
        start_frame(4, 16'h0009, ok);
        tx_valid[4] = 1'b0;
        capture(4, 1'b0, got, done_at, bad, rdy, bsy);
        n_checks++;
        if (!ok || got[7:0] !== 8'b0001_0011) begin
            n_fail++;
            $display("FAIL stop2_line got=%b exp=%b", got[7:0], 8'b0001_0011);
        end
        n_checks++;
        if (done_at != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL stop2_done got done_at=%0d bad=%0d exp 8/0", done_at, bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] got1, got2;
        int done1, done2, bad1, bad2;
        logic rdy1, bsy1, rdy2, bsy2;
        bit ok;
        start_frame(0, 16'h00A5, ok);
        tx_data[0] = 16'h003C;
        capture(0, 1'b0, got1, done1, bad1, rdy1, bsy1);
        n_checks++;
        if (!ok || got1 !== model_frame(0, 16'h00A5) || done1 != 11 || bad1 != 0) begin
            n_fail++;
            $display("FAIL b2b_first got=%h done_at=%0d bad=%0d exp=%h done_at=11",
                     got1, done1, bad1, model_frame(0, 16'h00A5));
        end
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        capture(0, 1'b0, got2, done2, bad2, rdy2, bsy2);
        n_checks++;
        if (got2 !== model_frame(0, 16'h003C) || bad2 != 0) begin
            n_fail++;
            $display("FAIL b2b_second got=%h bad=%0d exp=%h", got2, bad2, model_frame(0, 16'h003C));
        end
        n_checks++;
        if (done2 != 11 || rdy2 !== 1'b1 || bsy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done got done_at=%0d ready=%b busy=%b exp 11/1/0", done2, rdy2, bsy2);
        end
    endtask

    task automatic test_reset_midframe();
        logic [127:0] got;
        int done_at, bad, viol;
        logic rdy, bsy;
        bit ok;
        start_frame(0, 16'h00FF, ok);
        tx_valid[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (!ok || line[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre got sig=%b busy=%b exp 1/1", line[0], busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({line[0], busy[0], done[0], tx_ready[0]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_async got=%b exp=0001", {line[0], busy[0], done[0], tx_ready[0]});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        viol = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || line[0] !== 1'b0 || busy[0] !== 1'b0) viol++;
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL midreset_no_resume got=%0d bad cycles exp=0", viol); end
        start_frame(0, 16'h000F, ok);
        tx_valid[0] = 1'b0;
        capture(0, 1'b0, got, done_at, bad, rdy, bsy);
        n_checks++;
        if (!ok || got !== model_frame(0, 16'h000F) || done_at != 11 || bad != 0) begin
            n_fail++;
            $display("FAIL midreset_after got=%h done_at=%0d bad=%0d exp=%h done_at=11",
                     got, done_at, bad, model_frame(0, 16'h000F));
        end
    endtask

    task automatic test_random();
        logic [127:0] got, exp;
        int done_at, bad, k;
        logic rdy, bsy;
        logic [15:0] data;
        bit ok;
        for (int n = 0; n < 30; n++) begin
            k    = $urandom_range(0, NI - 1);
            data = 16'($urandom);
            exp  = model_frame(k, data);
            start_frame(k, data, ok);
            capture(k, 1'b1, got, done_at, bad, rdy, bsy);
            n_checks++;
            if (!ok || got !== exp) begin
                n_fail++;
                $display("FAIL random_line n=%0d k=%0d data=%h got=%h exp=%h", n, k, data, got, exp);
            end
            n_checks++;
            if (done_at != frame_len(k) + 1 || bad != 0 || rdy !== 1'b1 || bsy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_timing n=%0d k=%0d got done_at=%0d bad=%0d ready=%b busy=%b exp done_at=%0d",
                         n, k, done_at, bad, rdy, bsy, frame_len(k) + 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_slow_clock();
        test_stop_bits();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
